// File: rtl/rob_param.sv
// Parametrised reorder buffer: circular queue of in-flight instructions kept in
// program order. Results arrive over NCDB common data buses, operands are
// forwarded to the decoder, and one entry commits per cycle to the register
// file, the data cache (store handshake) or the branch predictor. A branch
// mispredict at the head empties the whole buffer.
module rob_param #(
   parameter int DEPTH  = 8,
   parameter int TAG_W  = 3,
   parameter int NCDB   = 2,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int REG_W  = 5,
   parameter int BP_W   = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alloc_valid,
   output logic                     alloc_ready,
   input  logic [2:0]               alloc_op,
   input  logic [REG_W-1:0]         alloc_rd,
   input  logic [BP_W-1:0]          alloc_bpaddr,
   input  logic                     alloc_pred,
   output logic [TAG_W-1:0]         alloc_tag,
   output logic [TAG_W:0]           count,
   input  logic [NCDB-1:0]          cdb_valid,
   input  logic [NCDB*TAG_W-1:0]    cdb_tag,
   input  logic [NCDB*DATA_W-1:0]   cdb_value,
   input  logic [NCDB*ADDR_W-1:0]   cdb_addr,
   input  logic [NCDB-1:0]          cdb_taken,
   input  logic [TAG_W-1:0]         chk_tag1,
   input  logic [TAG_W-1:0]         chk_tag2,
   output logic                     chk_ok1,
   output logic                     chk_ok2,
   output logic [DATA_W-1:0]        chk_data1,
   output logic [DATA_W-1:0]        chk_data2,
   output logic                     reg_we,
   output logic [REG_W-1:0]         reg_rd,
   output logic [DATA_W-1:0]        reg_data,
   output logic [TAG_W-1:0]         reg_tag,
   output logic                     st_req,
   output logic [3:0]               st_mask,
   output logic [ADDR_W-1:0]        st_addr,
   output logic [DATA_W-1:0]        st_data,
   input  logic                     st_ack,
   output logic                     misalign,
   output logic                     brp_update,
   output logic [BP_W-1:0]          brp_addr,
   output logic                     brp_taken,
   output logic                     flush,
   output logic [ADDR_W-1:0]        flush_pc
);

   localparam logic [2:0] OP_BR   = 3'd1;
   localparam logic [2:0] OP_NORM = 3'd2;
   localparam logic [2:0] OP_SB   = 3'd3;
   localparam logic [2:0] OP_SH   = 3'd4;
   localparam logic [2:0] OP_SW   = 3'd5;

   localparam logic [TAG_W:0]   FULL     = (TAG_W+1)'(DEPTH);
   localparam logic [TAG_W:0]   CNT_ZERO = {(TAG_W+1){1'b0}};
   localparam logic [TAG_W-1:0] PTR_ONE  = {{(TAG_W-1){1'b0}}, 1'b1};

   // Byte-lane mask for a store; zero means the access is misaligned.
   function automatic logic [3:0] lane_mask(input logic [2:0] kind, input logic [1:0] off);
      logic [3:0] m;
      case (kind)
         OP_SB:   m = 4'b0001 << off;
         OP_SH:   m = (off == 2'b00) ? 4'b0011 : ((off == 2'b10) ? 4'b1100 : 4'b0000);
         OP_SW:   m = (off == 2'b00) ? 4'b1111 : 4'b0000;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // entry storage
   logic [DEPTH-1:0]             e_busy, e_done, e_taken, e_pred;
   logic [DEPTH-1:0][2:0]        e_op;
   logic [DEPTH-1:0][REG_W-1:0]  e_rd;
   logic [DEPTH-1:0][DATA_W-1:0] e_value;
   logic [DEPTH-1:0][ADDR_W-1:0] e_addr;
   logic [DEPTH-1:0][BP_W-1:0]   e_bpaddr;
   logic [TAG_W-1:0]             head, tail;

   // per-port views of the flat CDB buses
   logic [NCDB-1:0][TAG_W-1:0]   p_tag;
   logic [NCDB-1:0][DATA_W-1:0]  p_value;
   logic [NCDB-1:0][ADDR_W-1:0]  p_addr;
   assign p_tag   = cdb_tag;
   assign p_value = cdb_value;
   assign p_addr  = cdb_addr;

   logic [2:0] h_op;
   logic [3:0] h_mask;
   logic       h_store, head_done, retire, mispredict, accept;

   assign alloc_ready = (count != FULL) && !flush;
   assign accept      = alloc_valid && alloc_ready;
   assign alloc_tag   = tail;

   // Decide what the head entry does this cycle.
   always_comb begin
      h_op       = e_op[head];
      h_mask     = lane_mask(h_op, e_addr[head][1:0]);
      h_store    = (h_op == OP_SB) || (h_op == OP_SH) || (h_op == OP_SW);
      // a pending store blocks any further head evaluation
      head_done  = (count != CNT_ZERO) && e_done[head] && !st_req;
      mispredict = head_done && (h_op == OP_BR) && (e_taken[head] != e_pred[head]);
      if (head_done && !(h_store && (h_mask != 4'b0000))) begin
         retire = 1'b1;
      end else if (st_req && st_ack) begin
         retire = 1'b1;
      end else begin
         retire = 1'b0;
      end
   end

   // Operand lookup: a live CDB result beats the stored value, lowest port first.
   always_comb begin
      chk_ok1   = e_done[chk_tag1];
      chk_data1 = e_value[chk_tag1];
      chk_ok2   = e_done[chk_tag2];
      chk_data2 = e_value[chk_tag2];
      for (int i = NCDB - 1; i >= 0; i--) begin
         if (cdb_valid[i] && (p_tag[i] == chk_tag1)) begin
            chk_ok1   = 1'b1;
            chk_data1 = p_value[i];
         end else begin
         end
         if (cdb_valid[i] && (p_tag[i] == chk_tag2)) begin
            chk_ok2   = 1'b1;
            chk_data2 = p_value[i];
         end else begin
         end
      end
   end

   // Buffer state: allocation, CDB write-back, retirement and flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         e_busy   <= '0;
         e_done   <= '0;
         e_taken  <= '0;
         e_pred   <= '0;
         e_op     <= '0;
         e_rd     <= '0;
         e_value  <= '0;
         e_addr   <= '0;
         e_bpaddr <= '0;
      end else if (mispredict) begin
         // everything younger than the branch is wrong-path; same-cycle alloc is dropped
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         e_busy <= '0;
         e_done <= '0;
      end else begin
         // walk ports high to low so the lowest index lands last and wins
         for (int i = NCDB - 1; i >= 0; i--) begin
            if (cdb_valid[i] && e_busy[p_tag[i]] && !e_done[p_tag[i]]) begin
               e_done[p_tag[i]]  <= 1'b1;
               e_value[p_tag[i]] <= p_value[i];
               e_addr[p_tag[i]]  <= p_addr[i];
               e_taken[p_tag[i]] <= cdb_taken[i];
            end
         end
         if (accept) begin
            e_busy[tail]   <= 1'b1;
            e_done[tail]   <= 1'b0;
            e_op[tail]     <= alloc_op;
            e_rd[tail]     <= alloc_rd;
            e_bpaddr[tail] <= alloc_bpaddr;
            e_pred[tail]   <= alloc_pred;
            tail           <= tail + PTR_ONE;
         end
         if (retire) begin
            e_busy[head] <= 1'b0;
            e_done[head] <= 1'b0;
            head         <= head + PTR_ONE;
         end
         count <= count + {{TAG_W{1'b0}}, accept} - {{TAG_W{1'b0}}, retire};
      end
   end

   // Registered commit outputs: pulses for regfile/predictor/flush, held store request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_we     <= 1'b0;
         reg_rd     <= '0;
         reg_data   <= '0;
         reg_tag    <= '0;
         st_req     <= 1'b0;
         st_mask    <= 4'b0000;
         st_addr    <= '0;
         st_data    <= '0;
         misalign   <= 1'b0;
         brp_update <= 1'b0;
         brp_addr   <= '0;
         brp_taken  <= 1'b0;
         flush      <= 1'b0;
         flush_pc   <= '0;
      end else begin
         reg_we     <= 1'b0;
         misalign   <= 1'b0;
         brp_update <= 1'b0;
         flush      <= mispredict;
         if (mispredict) begin
            flush_pc <= ADDR_W'(e_value[head]);
         end
         if (st_req && st_ack) begin
            st_req <= 1'b0;
         end
         if (head_done) begin
            case (h_op)
               OP_NORM: begin
                  reg_we   <= 1'b1;
                  reg_rd   <= e_rd[head];
                  reg_data <= e_value[head];
                  reg_tag  <= head;
               end
               OP_BR: begin
                  brp_update <= 1'b1;
                  brp_addr   <= e_bpaddr[head];
                  brp_taken  <= e_taken[head];
               end
               OP_SB, OP_SH, OP_SW: begin
                  if (h_mask != 4'b0000) begin
                     st_req  <= 1'b1;
                     st_mask <= h_mask;
                     st_addr <= e_addr[head] & {{(ADDR_W-2){1'b1}}, 2'b00};
                     st_data <= e_value[head] << {e_addr[head][1:0], 3'b000};
                  end else begin
                     misalign <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rob_param.sv
// Scoreboard bench for rob_param: stimulus pushes expected commit events,
// a negedge monitor pops and compares whenever the buffer commits something.
module tb_rob_param;
   localparam int DEPTH = 8, TAG_W = 3, NCDB = 2, DATA_W = 32, ADDR_W = 32, REG_W = 5, BP_W = 10;

   logic                   clk, rst;
   logic                   alloc_valid, alloc_ready, alloc_pred;
   logic [2:0]             alloc_op;
   logic [REG_W-1:0]       alloc_rd;
   logic [BP_W-1:0]        alloc_bpaddr;
   logic [TAG_W-1:0]       alloc_tag;
   logic [TAG_W:0]         count;
   logic [NCDB-1:0]        cdb_valid, cdb_taken;
   logic [NCDB*TAG_W-1:0]  cdb_tag;
   logic [NCDB*DATA_W-1:0] cdb_value;
   logic [NCDB*ADDR_W-1:0] cdb_addr;
   logic [TAG_W-1:0]       chk_tag1, chk_tag2;
   logic                   chk_ok1, chk_ok2;
   logic [DATA_W-1:0]      chk_data1, chk_data2;
   logic                   reg_we;
   logic [REG_W-1:0]       reg_rd;
   logic [DATA_W-1:0]      reg_data;
   logic [TAG_W-1:0]       reg_tag;
   logic                   st_req, st_ack, misalign, brp_update, brp_taken, flush;
   logic [3:0]             st_mask;
   logic [ADDR_W-1:0]      st_addr, flush_pc;
   logic [DATA_W-1:0]      st_data;
   logic [BP_W-1:0]        brp_addr;

   rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NCDB(NCDB), .DATA_W(DATA_W),
               .ADDR_W(ADDR_W), .REG_W(REG_W), .BP_W(BP_W)) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
      .alloc_rd(alloc_rd), .alloc_bpaddr(alloc_bpaddr), .alloc_pred(alloc_pred),
      .alloc_tag(alloc_tag), .count(count),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .cdb_addr(cdb_addr), .cdb_taken(cdb_taken),
      .chk_tag1(chk_tag1), .chk_tag2(chk_tag2), .chk_ok1(chk_ok1), .chk_ok2(chk_ok2),
      .chk_data1(chk_data1), .chk_data2(chk_data2),
      .reg_we(reg_we), .reg_rd(reg_rd), .reg_data(reg_data), .reg_tag(reg_tag),
      .st_req(st_req), .st_mask(st_mask), .st_addr(st_addr), .st_data(st_data),
      .st_ack(st_ack), .misalign(misalign),
      .brp_update(brp_update), .brp_addr(brp_addr), .brp_taken(brp_taken),
      .flush(flush), .flush_pc(flush_pc)
   );

   typedef struct {
      int          kind;   // 1 reg, 2 store, 3 misalign, 4 branch
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
   } ev_t;

   ev_t sb_q[$];
   int  vectors     = 0;
   int  miscompares = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      ev_t e;
      e.kind = kind; e.a = a; e.b = b; e.c = c;
      sb_q.push_back(e);
   endtask

   task automatic expect_ev(input string name, input int kind, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] c);
      ev_t e;
      if (sb_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: got unexpected event %0h/%0h/%0h expected none", name, a, b, c);
      end else begin
         e = sb_q.pop_front();
         check(name, {kind, a, b, c}, {e.kind, e.a, e.b, e.c});
      end
   endtask

   // monitor: compare every commit-side event against the scoreboard
   always @(negedge clk) begin
      if (rst) begin
         if (reg_we)
            expect_ev("reg_commit", 1, 32'(reg_rd), reg_data, 32'(reg_tag));
         if (st_req && st_ack)
            expect_ev("store", 2, 32'(st_mask), st_addr, st_data);
         if (misalign)
            expect_ev("misalign", 3, 32'd0, 32'd0, 32'd0);
         if (brp_update)
            expect_ev("branch", 4, 32'(brp_addr), {30'd0, flush, brp_taken},
                      flush ? flush_pc : 32'd0);
         else if (flush)
            expect_ev("flush_without_update", 5, 32'd0, 32'd0, 32'(flush_pc));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_alloc(input logic [2:0] o, input logic [4:0] rd, input logic [9:0] bp, input logic p);
      alloc_valid  = 1'b1;
      alloc_op     = o;
      alloc_rd     = rd;
      alloc_bpaddr = bp;
      alloc_pred   = p;
      tick();
      alloc_valid  = 1'b0;
   endtask

   task automatic set_cdb(input int port, input logic [2:0] tag, input logic [31:0] val,
                          input logic [31:0] addr, input logic tk);
      cdb_valid[port]                  = 1'b1;
      cdb_tag[port*TAG_W +: TAG_W]     = tag;
      cdb_value[port*DATA_W +: DATA_W] = val;
      cdb_addr[port*ADDR_W +: ADDR_W]  = addr;
      cdb_taken[port]                  = tk;
   endtask

   task automatic wait_empty(input string name, input int budget);
      int n = 0;
      while (count != 4'd0 && n < budget) begin
         tick();
         n++;
      end
      check(name, 128'(count), 128'(0));
   endtask

   initial begin
      int n;
      rst = 1'b0;
      alloc_valid = 1'b0; alloc_op = 3'd0; alloc_rd = '0; alloc_bpaddr = '0; alloc_pred = 1'b0;
      cdb_valid = '0; cdb_tag = '0; cdb_value = '0; cdb_addr = '0; cdb_taken = '0;
      chk_tag1 = '0; chk_tag2 = '0; st_ack = 1'b0;
      tick(); tick();
      check("reset_count", 128'(count), 128'(0));
      check("reset_alloc_ready", 128'(alloc_ready), 128'(1));
      check("reset_outputs", 128'({reg_we, st_req, flush, brp_update, misalign}), 128'(0));
      check("reset_alloc_tag", 128'(alloc_tag), 128'(0));
      rst = 1'b1;
      tick();

      // fill: tags 0..7, then full
      for (int i = 0; i < 8; i++) begin
         check("fill_tag", 128'(alloc_tag), 128'(i));
         do_alloc(3'd2, 5'(i), 10'd0, 1'b0);
      end
      check("full_count", 128'(count), 128'(8));
      check("full_not_ready", 128'(alloc_ready), 128'(0));
      do_alloc(3'd2, 5'd9, 10'd0, 1'b0);
      check("ninth_ignored", 128'(count), 128'(8));
      for (int i = 0; i < 8; i++) push(1, 32'(i), 32'h100 + 32'(i), 32'(i));
      for (int i = 0; i < 4; i++) begin
         set_cdb(0, 3'(2*i), 32'h100 + 32'(2*i), 32'd0, 1'b0);
         set_cdb(1, 3'(2*i+1), 32'h100 + 32'(2*i+1), 32'd0, 1'b0);
         tick();
         cdb_valid = '0;
      end
      wait_empty("fill_drain", 30);

      // normal commit
      check("normal_tag", 128'(alloc_tag), 128'(0));
      do_alloc(3'd2, 5'd5, 10'd0, 1'b0);
      push(1, 32'd5, 32'h1234, 32'd0);
      set_cdb(0, 3'd0, 32'h1234, 32'd0, 1'b0);
      tick();
      cdb_valid = '0;
      tick(); tick();
      check("normal_count", 128'(count), 128'(0));

      // forwarding, tags 1..3
      push(1, 32'd1, 32'h11, 32'd1);
      push(1, 32'd2, 32'h22, 32'd2);
      push(1, 32'd3, 32'hAB, 32'd3);
      do_alloc(3'd2, 5'd1, 10'd0, 1'b0);
      do_alloc(3'd2, 5'd2, 10'd0, 1'b0);
      do_alloc(3'd2, 5'd3, 10'd0, 1'b0);
      set_cdb(1, 3'd3, 32'hAB, 32'd0, 1'b0);
      chk_tag1 = 3'd3; chk_tag2 = 3'd2;
      #1;
      check("fwd_ok1", 128'(chk_ok1), 128'(1));
      check("fwd_data1", 128'(chk_data1), 128'(32'hAB));
      check("fwd_ok2_pending", 128'(chk_ok2), 128'(0));
      tick();
      cdb_valid = '0;
      set_cdb(0, 3'd2, 32'h22, 32'd0, 1'b0);
      set_cdb(1, 3'd2, 32'h99, 32'd0, 1'b0);
      chk_tag1 = 3'd2;
      #1;
      check("fwd_dual_port0", 128'(chk_data1), 128'(32'h22));
      tick();
      cdb_valid = '0;
      #1;
      check("stored_ok2", 128'(chk_ok2), 128'(1));
      check("stored_data2", 128'(chk_data2), 128'(32'h22));
      set_cdb(0, 3'd1, 32'h11, 32'd0, 1'b0);
      tick();
      cdb_valid = '0;
      wait_empty("fwd_drain", 20);

      // store byte at 0x1003, held until ack
      push(2, 32'h8, 32'h1000, 32'h7F000000);
      do_alloc(3'd3, 5'd0, 10'd0, 1'b0);
      set_cdb(0, 3'd4, 32'h7F, 32'h1003, 1'b0);
      tick();
      cdb_valid = '0;
      n = 0;
      while (!st_req && n < 10) begin tick(); n++; end
      check("st_req_raised", 128'(st_req), 128'(1));
      for (int h = 0; h < 3; h++) begin
         check("st_hold", 128'({st_req, st_mask, st_addr}), 128'({1'b1, 4'b1000, 32'h1000}));
         tick();
      end
      st_ack = 1'b1;
      tick();
      st_ack = 1'b0;
      check("st_req_dropped", 128'(st_req), 128'(0));
      check("store_count", 128'(count), 128'(0));

      // misaligned half, aligned half at offset 2, word
      st_ack = 1'b1;
      push(3, 32'd0, 32'd0, 32'd0);
      push(2, 32'hC, 32'h1000, 32'h56780000);
      push(2, 32'hF, 32'h2004, 32'hCAFEF00D);
      do_alloc(3'd4, 5'd0, 10'd0, 1'b0);
      do_alloc(3'd4, 5'd0, 10'd0, 1'b0);
      do_alloc(3'd5, 5'd0, 10'd0, 1'b0);
      set_cdb(0, 3'd5, 32'hBEEF, 32'h1, 1'b0);
      set_cdb(1, 3'd6, 32'h5678, 32'h1002, 1'b0);
      tick();
      cdb_valid = '0;
      set_cdb(0, 3'd7, 32'hCAFEF00D, 32'h2004, 1'b0);
      tick();
      cdb_valid = '0;
      wait_empty("store_mix_drain", 20);
      st_ack = 1'b0;

      // mispredict with three younger entries
      push(4, 32'h2A, 32'd3, 32'h400);
      do_alloc(3'd1, 5'd0, 10'h2A, 1'b0);
      do_alloc(3'd2, 5'd7, 10'd0, 1'b0);
      do_alloc(3'd2, 5'd8, 10'd0, 1'b0);
      do_alloc(3'd2, 5'd9, 10'd0, 1'b0);
      set_cdb(1, 3'd0, 32'h400, 32'd0, 1'b1);
      tick();
      cdb_valid = '0;
      n = 0;
      while (!flush && n < 10) begin tick(); n++; end
      check("flush_seen", 128'(flush), 128'(1));
      check("flush_count", 128'(count), 128'(0));
      check("flush_tail", 128'(alloc_tag), 128'(0));
      check("flush_not_ready", 128'(alloc_ready), 128'(0));
      tick();
      check("post_flush_ready", 128'(alloc_ready), 128'(1));

      // wrap: 20 alloc/retire pairs at count 1
      check("wrap_start_tag", 128'(alloc_tag), 128'(0));
      do_alloc(3'd2, 5'd1, 10'd0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         push(1, 32'(k + 1), 32'h5000 + 32'(k), 32'(k % 8));
         set_cdb(0, 3'(k % 8), 32'h5000 + 32'(k), 32'd0, 1'b0);
         tick();
         cdb_valid = '0;
         check("wrap_tag", 128'(alloc_tag), 128'((k + 1) % 8));
         do_alloc(3'd2, 5'(k + 2), 10'd0, 1'b0);
         check("wrap_count", 128'(count), 128'(1));
      end
      push(1, 32'd21, 32'h5014, 32'd4);
      set_cdb(0, 3'd4, 32'h5014, 32'd0, 1'b0);
      tick();
      cdb_valid = '0;
      wait_empty("wrap_drain", 10);

      // async reset while a store waits for ack
      do_alloc(3'd5, 5'd0, 10'd0, 1'b0);
      set_cdb(0, 3'd5, 32'h11223344, 32'h3000, 1'b0);
      tick();
      cdb_valid = '0;
      n = 0;
      while (!st_req && n < 10) begin tick(); n++; end
      check("rst_store_pending", 128'(st_req), 128'(1));
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_outputs", 128'({st_req, st_mask, st_addr, st_data}), 128'(0));
      check("async_rst_state", 128'({count, alloc_tag, reg_we, flush}), 128'(0));
      check("async_rst_ready", 128'(alloc_ready), 128'(1));
      tick();
      rst = 1'b1;
      tick(); tick();
      check("scoreboard_drained", 128'(sb_q.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
